// File: rtl/gf_feed_pkg.sv
// Shared constants and helpers for the GF(2^m) multiplier feeder.
// GF16_POLY is the x^16+x^5+x^3+x+1 reference polynomial with the x^16 term implied.
package gf_feed_pkg;

  localparam int GF_WIDTH   = 16;
  localparam int GF_LATENCY = 12;
  localparam int GF_DEPTH   = 4;

  localparam logic [15:0] GF16_POLY = 16'h002B;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gf_feed_fifo.sv
// Show-ahead result FIFO: power-of-two depth, wrap-bit pointers, head entry
// visible on rd_data without a read request.
module gf_feed_fifo
  import gf_feed_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DW-1:0]           wr_data,
  input  logic                    pop,
  output logic [DW-1:0]           rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  // Storage carries no reset; empty gating downstream hides stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  assert property (@(posedge clk) disable iff (!rst) !(push && full));
  assert property (@(posedge clk) disable iff (!rst) !(pop && empty));

endmodule

// File: rtl/gf_mul_feeder.sv
// Host-side feeder for the GF(2^m) systolic multiplier: launches operand
// triples, tracks them through a latency pipe and returns results in order.
// Optional tag path enabled by defining GF_FEED_TAG_EN.
module gf_mul_feeder
  import gf_feed_pkg::*;
#(
  parameter int WIDTH   = GF_WIDTH,
  parameter int LATENCY = GF_LATENCY,
`ifdef GF_FEED_TAG_EN
  parameter int TAG_W   = 4,
`endif
  parameter int DEPTH   = GF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_a,
  input  logic [WIDTH-1:0] s_b,
  input  logic [WIDTH-1:0] s_g,
  output logic             arr_ctr,
  output logic [WIDTH-1:0] arr_ai,
  output logic [WIDTH-1:0] arr_bi,
  output logic [WIDTH-1:0] arr_gi,
  input  logic [WIDTH-1:0] arr_po,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
`ifdef GF_FEED_TAG_EN
  input  logic [TAG_W-1:0] s_tag,
  output logic [TAG_W-1:0] m_tag,
`endif
  output logic             busy
);

  localparam int CW = clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
`ifdef GF_FEED_TAG_EN
  localparam int DW = WIDTH + TAG_W;
`else
  localparam int DW = WIDTH;
`endif

  logic             s_ready_reg;
  logic             ctr_reg;
  logic [WIDTH-1:0] a_reg, b_reg, g_reg;
  logic [LATENCY:0] pipe_reg;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             accept, pop, push;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [DW-1:0]    fifo_wr_data, fifo_rd_data;

  assign accept = s_valid && s_ready_reg;
  assign pop    = !fifo_empty && m_ready;
  // Stage LATENCY is high exactly in the cycle the array presents the result.
  assign push   = pipe_reg[LATENCY];

  // Credits cover both in-flight ops and buffered results, so a launched op
  // always has a FIFO slot waiting for it.
  always_comb begin
    cnt_next = cnt_reg;
    if (accept && !pop)      cnt_next = cnt_reg + CNT_ONE;
    else if (pop && !accept) cnt_next = cnt_reg - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_ready_reg <= 1'b0;
      ctr_reg     <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      g_reg       <= '0;
      pipe_reg    <= '0;
      cnt_reg     <= '0;
    end else begin
      s_ready_reg <= (cnt_next < DEPTH_C);
      ctr_reg     <= accept;
      cnt_reg     <= cnt_next;
      pipe_reg    <= {pipe_reg[LATENCY-1:0], accept};
      if (accept) begin
        a_reg <= s_a;
        b_reg <= s_b;
        g_reg <= s_g;
      end
    end
  end

`ifdef GF_FEED_TAG_EN
  logic [TAG_W-1:0] tag_pipe_reg [LATENCY+1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= LATENCY; i++) tag_pipe_reg[i] <= '0;
    end else begin
      tag_pipe_reg[0] <= s_tag;
      for (int i = 1; i <= LATENCY; i++) tag_pipe_reg[i] <= tag_pipe_reg[i-1];
    end
  end

  assign fifo_wr_data = {tag_pipe_reg[LATENCY], arr_po};
  assign m_tag        = fifo_empty ? '0 : fifo_rd_data[DW-1:WIDTH];
`else
  assign fifo_wr_data = arr_po;
`endif

  gf_feed_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (fifo_wr_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign s_ready = s_ready_reg;
  assign arr_ctr = ctr_reg;
  assign arr_ai  = a_reg;
  assign arr_bi  = b_reg;
  assign arr_gi  = g_reg;
  assign m_valid = !fifo_empty;
  assign m_data  = fifo_empty ? '0 : fifo_rd_data[WIDTH-1:0];
  assign busy    = (cnt_reg != '0);

  assert property (@(posedge clk) disable iff (!rst)
    (fifo_count <= cnt_reg) && (!fifo_full || cnt_reg == DEPTH_C));

endmodule

// File: tb/tb_gf_mul_feeder.sv
// Self-checking bench for gf_mul_feeder: behavioural fixed-latency array
// model, polynomial-arithmetic reference and an in-order scoreboard.
module tb_gf_mul_feeder;
  import gf_feed_pkg::*;

  localparam int W     = 16;
  localparam int LAT   = 12;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_a = '0, s_b = '0, s_g = '0;
  logic          arr_ctr;
  logic [W-1:0]  arr_ai, arr_bi, arr_gi, arr_po;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [W-1:0]  m_data;
  logic          busy;
  logic [3:0]    s_tag = '0;
`ifdef GF_FEED_TAG_EN
  logic [3:0]    m_tag;
`endif

  gf_mul_feeder dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_a     (s_a),
    .s_b     (s_b),
    .s_g     (s_g),
    .arr_ctr (arr_ctr),
    .arr_ai  (arr_ai),
    .arr_bi  (arr_bi),
    .arr_gi  (arr_gi),
    .arr_po  (arr_po),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
`ifdef GF_FEED_TAG_EN
    .s_tag   (s_tag),
    .m_tag   (m_tag),
`endif
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Polynomial product over GF(2), then long division by x^16 + g.
  function automatic logic [15:0] gf_ref(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] g);
    logic [31:0] prod;
    logic [31:0] modp;
    prod = '0;
    modp = {15'd0, 1'b1, g};
    for (int i = 0; i < 16; i++) if (b[i]) prod = prod ^ ({16'd0, a} << i);
    for (int i = 30; i >= 16; i--) if (prod[i]) prod = prod ^ (modp << (i - 16));
    return prod[15:0];
  endfunction

  // Array model: result appears on arr_po LAT cycles after the ctr-high cycle;
  // other cycles carry random garbage.
  logic [W-1:0] dl [LAT];
  always @(posedge clk) begin
    dl[0] <= arr_ctr ? gf_ref(arr_ai, arr_bi, arr_gi) : W'($urandom);
    for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
  end
  assign arr_po = dl[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampling at the falling edge.
  logic [31:0] exp_q[$];
  logic [31:0] exp_e;
  bit          mon_en = 1'b0;
  bit          prev_acc = 1'b0;
  int          sz;
  int          acc_n = 0;
  int          pop_n = 0;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      prev_acc = 1'b0;
    end else if (mon_en) begin
      sz = exp_q.size();
      check("arr_ctr", {31'd0, arr_ctr}, {31'd0, prev_acc});
      check("s_ready_credit", {31'd0, s_ready}, {31'd0, sz < DEPTH});
      check("busy", {31'd0, busy}, {31'd0, sz != 0});
      if (sz == 0) begin
        check("m_valid_idle", {31'd0, m_valid}, 32'd0);
      end else if (m_valid && m_ready) begin
        exp_e = exp_q.pop_front();
        check("m_data", {16'd0, m_data}, {16'd0, exp_e[15:0]});
`ifdef GF_FEED_TAG_EN
        check("m_tag", {28'd0, m_tag}, {28'd0, exp_e[19:16]});
`endif
        pop_n++;
      end
      prev_acc = s_valid && s_ready;
      if (prev_acc) begin
        exp_q.push_back({12'd0, s_tag, gf_ref(s_a, s_b, s_g)});
        acc_n++;
      end
    end
  end

  int acc_cyc = 0;
  int res_cyc = 0;

  // Call at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] g, input logic [3:0] tag);
    int guard;
    guard = 0;
    s_valid = 1'b1; s_a = a; s_b = b; s_g = g; s_tag = tag;
    @(negedge clk);
    while (!s_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("send_ready", {31'd0, s_ready}, 32'd1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic get_result(input logic [15:0] exp, input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!m_valid && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    res_cyc = cyc;
    check(tag, {16'd0, m_data}, {16'd0, exp});
    @(posedge clk); #1; m_ready = 1'b1;
    @(posedge clk); #1; m_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    check({tag, "_arr_ctr"}, {31'd0, arr_ctr}, 32'd0);
    check({tag, "_arr_ops"}, {arr_ai | arr_bi | arr_gi}, 32'd0);
    check({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    check({tag, "_m_data"}, {16'd0, m_data}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int guard;
    int start_acc;
    int saw;
    logic [3:0] tags [3];

    // Reset state and release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #3; rst = 1'b1;
    @(posedge clk); #1; mon_en = 1'b1;
    @(negedge clk);
    check("s_ready_release", {31'd0, s_ready}, 32'd1);
    @(posedge clk); #1;

    // Single op with latency measurement.
    send(16'h0001, 16'h1234, GF16_POLY, 4'h1);
    get_result(16'h1234, "single");
    check("single_latency", res_cyc - acc_cyc, LAT + 2);
    @(negedge clk);
    check("single_busy_low", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Reduction cases.
    send(16'h0002, 16'h8000, GF16_POLY, 4'h2);
    get_result(16'h002B, "reduce_x16");
    send(16'h8000, 16'h8000, GF16_POLY, 4'h3);
    get_result(gf_ref(16'h8000, 16'h8000, GF16_POLY), "reduce_x30");

    // Back-to-back fill with consumer stalled, then drain.
    for (int i = 0; i < 4; i++) send(16'(i + 3), 16'(16'h0101 * (i + 1)), GF16_POLY, 4'(i));
    @(negedge clk);
    check("b2b_full_ready", {31'd0, s_ready}, 32'd0);
    repeat (LAT + 4) @(posedge clk);
    @(negedge clk);
    check("b2b_buffered_valid", {31'd0, m_valid}, 32'd1);
    check("b2b_buffered_ready", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1; m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("b2b_drain_valid", {31'd0, m_valid}, 32'd1);
      if (k == 1) check("b2b_ready_after_pop", {31'd0, s_ready}, 32'd1);
      @(posedge clk); #1;
    end
    m_ready = 1'b0;
    @(negedge clk);
    check("b2b_empty", {31'd0, m_valid}, 32'd0);
    @(posedge clk); #1;

`ifdef GF_FEED_TAG_EN
    tags[0] = 4'h3; tags[1] = 4'hA; tags[2] = 4'h5;
    for (int i = 0; i < 3; i++) send(16'(16'h0011 * (i + 1)), 16'h00F0, GF16_POLY, tags[i]);
    repeat (LAT + 4) @(posedge clk);
    #1; m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("tag_order", {28'd0, m_tag}, {28'd0, tags[k]});
      @(posedge clk); #1;
    end
    m_ready = 1'b0;
`else
    tags[0] = 4'h0; tags[1] = 4'h0; tags[2] = 4'h0;
`endif

    // Random stream.
    start_acc = acc_n;
    guard = 0;
    while ((acc_n - start_acc) < 1000 && guard < 20000) begin
      @(posedge clk); #1;
      s_valid = 1'($urandom_range(0, 1));
      s_a = 16'($urandom);
      s_b = 16'($urandom);
      s_g = ($urandom_range(0, 3) == 0) ? GF16_POLY : 16'($urandom);
      s_tag = 4'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      guard++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    check("rand_accepts", acc_n - start_acc, 1000);
    guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("rand_drained", {31'd0, busy}, 32'd0);
    check("rand_queue_empty", exp_q.size(), 0);
    check("rand_no_drop", pop_n, acc_n);
    @(posedge clk); #1; m_ready = 1'b0;

    // Reset mid-flight.
    for (int i = 0; i < 3; i++) send(16'(16'h0F00 + i), 16'h0033, GF16_POLY, tags[i]);
    repeat (2) @(posedge clk);
    #3; mon_en = 1'b0; rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst_a");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst_b");
    @(posedge clk); #3; rst = 1'b1;
    @(posedge clk); #1; mon_en = 1'b1; m_ready = 1'b1;
    saw = 0;
    repeat (30) begin
      @(negedge clk);
      if (m_valid) saw++;
    end
    check("midrst_no_stale", saw, 0);
    check("midrst_ready", {31'd0, s_ready}, 32'd1);
    m_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
